ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; sits between the ID/EX control/operand bus and the memory stage.
- Decodes ALU control, selects operands and destination register, computes the ALU result, zero flag and branch target.
- Registers everything into the EX/MEM latch that feeds the memory stage.
- Adds an iterative 32-cycle shift-add multiplier (MULT, low word only) that stalls upstream while busy.

Parameters:
- DATA_W, 32: datapath width; the multiplier iteration count equals DATA_W.
- REG_W, 5: register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  branch taken downstream; kill the current EX instruction.
- id_ex_valid  in  1  ID/EX holds a real instruction.
- id_ex_wb  in  2  {regWrite, memReg}, passed through.
- id_ex_m  in  3  {branch, memRead, memWrite}.
- id_ex_ex  in  4  {regDst, aluOp[1:0], aluSrc}.
- id_ex_npc  in  DATA_W  PC+4.
- read_data1, read_data2  in  DATA_W  register operands.
- sign_ext_imm  in  DATA_W  sign-extended immediate; bits [5:0] are funct.
- rt, rd  in  REG_W  candidate destinations.
- stall  out  1  hold PC, IF/ID and ID/EX.
- ex_mem_branch, ex_mem_zero, ex_mem_memread, ex_mem_memwrite  out  1 each  registered control to the memory stage.
- ex_mem_wb  out  2  registered WB control.
- ex_mem_rd  out  REG_W  registered destination register.
- ex_mem_alu_result  out  DATA_W  memory address or ALU result.
- ex_mem_write_data  out  DATA_W  store data (registered read_data2).
- ex_mem_branch_target  out  DATA_W  npc + (imm<<2).

Behaviour:
- Reset (asynchronous): all ex_mem_* outputs 0, FSM to IDLE, multiplier registers 0, stall 0.
- ALU control:
  - aluOp 00: add.
  - aluOp 01: sub.
  - aluOp 11: slt (signed).
  - aluOp 10 decodes funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x18 MULT; any other funct is add.
- Operand B = aluSrc ? sign_ext_imm : read_data2.
- Destination = regDst ? rd : rt.
- Arithmetic is modulo 2^DATA_W; overflow is ignored.
- slt yields 1 or 0 in bit 0 with upper bits zero.
- zero = (ALU result == 0).
- Branch target = npc + (sign_ext_imm << 2), wrapping modulo 2^DATA_W.
- Non-MULT instructions take 1 cycle: the EX/MEM latch loads on every edge when not stalled.
- Invalid input (id_ex_valid=0) loads a bubble: all control bits 0; data fields don't-care, driven 0.
- FSM states: IDLE, MUL, DONE.
  - IDLE: a valid MULT on the inputs gives combinational stall=1. On the edge, latch multiplicand/multiplier, set product=0, set count=0, go to MUL. EX/MEM loads a bubble.
  - MUL: stall=1. Each edge: if multiplier[0], product += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. EX/MEM loads a bubble each edge. After DATA_W iterations, go to DONE.
  - DONE: stall=0. EX/MEM loads the product (low DATA_W bits) with the instruction's wb/m/rd. Go to IDLE.
- MULT latency: stall is high for DATA_W+1 cycles; the result appears in EX/MEM after DATA_W+2 edges from issue.
- Upstream holds the ID/EX inputs constant while stall=1. DONE ignores the inputs for re-triggering, so no double issue occurs.
- Priority: rst > flush > stall/normal.
  - flush=1 loads a bubble and forces the FSM to IDLE (multiply aborted); stall drops in the following cycle.
  - flush in DONE discards the product.
- Reset mid-multiply: immediate return to IDLE with outputs zeroed, per the reset rule.

Decomposition:
- Package ex_pkg holds:
  - aluOp encodings.
  - funct constants (ADD, SUB, AND, OR, SLT, MULT).
  - internal ALU operation enum.
  - FSM state enum {IDLE, MUL, DONE}.
  - control-bus field index constants for id_ex_m and id_ex_ex.
- Sub-module ex_mult_iter holds the shift-add datapath and counter, with start, busy, done and product ports. ex_stage owns the FSM, ALU, muxes and the EX/MEM latch.

Test Plan:
- After rst release: add rs=5, rt=7 (aluOp 10, funct 0x20, regDst=1, rd=3, wb=10) -> next edge ex_mem_alu_result=12, ex_mem_rd=3, ex_mem_wb=10, zero=0, stall=0.
- beq: rs=rt=0x10, aluOp 01, branch=1, npc=0x40, imm=3 -> ex_mem_zero=1, ex_mem_branch=1, ex_mem_branch_target=0x4C.
- lw: read_data1=0x100, imm=0xFFFFFFFC, aluSrc=1, memRead=1, rt=9 -> alu_result=0xFC, ex_mem_rd=9, memread=1. sw variant: write_data equals read_data2=0xABCDEF12, memwrite=1.
- MULT 0x0000FFFF x 0x00010001 -> stall high 33 cycles with bubbles in EX/MEM; then alu_result=0xFFFFFFFF and the instruction's wb/rd. Back-to-back add follows one cycle later with no re-trigger. Also check 0x12345678 x 0x10 -> 0x23456780.
- flush asserted 10 cycles into a MULT -> bubble loaded, stall 0 next cycle, FSM IDLE; a following add executes normally.
- rst pulsed mid-MULT (asynchronously, between edges) -> all ex_mem_* outputs and stall go to 0 immediately. slt with 0xFFFFFFFF vs 1 -> result 1.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, funct codes,
// control-bus field positions, FSM states and the ALU control decoder.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  // id_ex_m = {branch, memRead, memWrite}; id_ex_ex = {regDst, aluOp[1:0], aluSrc}
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MULT} alu_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_SLT: op = ALU_SLT;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB:  op = ALU_SUB;
          FUNCT_AND:  op = ALU_AND;
          FUNCT_OR:   op = ALU_OR;
          FUNCT_SLT:  op = ALU_SLT;
          FUNCT_MULT: op = ALU_MULT;
          default:    op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_mult_iter.sv
// Iterative shift-add multiplier datapath (low word only); one partial
// product per cycle while busy, sequenced by the owning FSM.
module ex_mult_iter import ex_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              busy,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  count;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      product <= '0;
      count   <= '0;
    end else if (busy) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
    end
  end

  // High during the final iteration, so the FSM leaves MUL on that edge.
  assign done = busy && (count == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU control, operand/destination muxes, ALU, branch target,
// multi-cycle MULT sequencing and the EX/MEM pipeline latch.
module ex_stage import ex_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_ex_valid,
  input  logic [1:0]        id_ex_wb,
  input  logic [2:0]        id_ex_m,
  input  logic [3:0]        id_ex_ex,
  input  logic [DATA_W-1:0] id_ex_npc,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_ext_imm,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  output logic              stall,
  output logic              ex_mem_branch,
  output logic              ex_mem_zero,
  output logic              ex_mem_memread,
  output logic              ex_mem_memwrite,
  output logic [1:0]        ex_mem_wb,
  output logic [REG_W-1:0]  ex_mem_rd,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_write_data,
  output logic [DATA_W-1:0] ex_mem_branch_target
);

  state_e            state, next_state;
  alu_op_e           op;
  logic [DATA_W-1:0] op_b, alu_y, branch_target, product, res;
  logic [REG_W-1:0]  dest;
  logic              is_mult, mult_start, mult_busy, mult_done, load;

  assign op            = alu_decode(id_ex_ex[EX_ALUOP_HI:EX_ALUOP_LO], sign_ext_imm[5:0]);
  assign op_b          = id_ex_ex[EX_ALUSRC] ? sign_ext_imm : read_data2;
  assign dest          = id_ex_ex[EX_REGDST] ? rd : rt;
  assign branch_target = id_ex_npc + (sign_ext_imm << 2);
  assign is_mult       = id_ex_valid && (op == ALU_MULT);

  always_comb begin
    alu_y = read_data1 + op_b;
    case (op)
      ALU_SUB: alu_y = read_data1 - op_b;
      ALU_AND: alu_y = read_data1 & op_b;
      ALU_OR:  alu_y = read_data1 | op_b;
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(read_data1) < $signed(op_b))};
      default: ;
    endcase
  end

  ex_mult_iter #(.DATA_W(DATA_W)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .busy    (mult_busy),
    .a       (read_data1),
    .b       (read_data2),
    .done    (mult_done),
    .product (product)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a value unassigned and infers a latch.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    mult_start = 1'b0;
    mult_busy  = 1'b0;
    case (state)
      IDLE: if (is_mult) begin
        stall      = 1'b1;
        mult_start = 1'b1;
        next_state = MUL;
      end
      MUL: begin
        stall     = 1'b1;
        mult_busy = 1'b1;
        if (mult_done) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) begin
      next_state = IDLE;
      mult_start = 1'b0;
      mult_busy  = 1'b0;
    end
    // Stall must drop the instant reset asserts, not at the next edge.
    if (rst) stall = 1'b0;
  end

  assign res  = (state == DONE) ? product : alu_y;
  assign load = !flush && ((state == DONE) || (state == IDLE && id_ex_valid && !is_mult));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      ex_mem_branch        <= 1'b0;
      ex_mem_zero          <= 1'b0;
      ex_mem_memread       <= 1'b0;
      ex_mem_memwrite      <= 1'b0;
      ex_mem_wb            <= '0;
      ex_mem_rd            <= '0;
      ex_mem_alu_result    <= '0;
      ex_mem_write_data    <= '0;
      ex_mem_branch_target <= '0;
    end else begin
      state                <= next_state;
      ex_mem_branch        <= load && id_ex_m[M_BRANCH];
      ex_mem_memread       <= load && id_ex_m[M_MEMREAD];
      ex_mem_memwrite      <= load && id_ex_m[M_MEMWRITE];
      ex_mem_zero          <= load && (res == '0);
      ex_mem_wb            <= load ? id_ex_wb      : '0;
      ex_mem_rd            <= load ? dest          : '0;
      ex_mem_alu_result    <= load ? res           : '0;
      ex_mem_write_data    <= load ? read_data2    : '0;
      ex_mem_branch_target <= load ? branch_target : '0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table of single-cycle vectors plus
// hand-written MULT, flush and reset sequences.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, id_ex_valid;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc, read_data1, read_data2, sign_ext_imm;
  logic [4:0]  rt, rd;
  logic        stall, ex_mem_branch, ex_mem_zero, ex_mem_memread, ex_mem_memwrite;
  logic [1:0]  ex_mem_wb;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_alu_result, ex_mem_write_data, ex_mem_branch_target;

  int n_checks = 0;
  int n_err    = 0;

  ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_ex_valid(id_ex_valid),
    .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex), .id_ex_npc(id_ex_npc),
    .read_data1(read_data1), .read_data2(read_data2), .sign_ext_imm(sign_ext_imm),
    .rt(rt), .rd(rd), .stall(stall),
    .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_wb(ex_mem_wb), .ex_mem_rd(ex_mem_rd), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_write_data(ex_mem_write_data), .ex_mem_branch_target(ex_mem_branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc, rd1, rd2, imm;
    logic [4:0]  rt, rd;
    logic [31:0] e_alu;
    logic        e_zero;
    logic [4:0]  e_rd;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [31:0] e_wdata, e_bt;
  } vec_t;

  vec_t vecs[12];
  vec_t add_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    id_ex_valid  = v.valid;
    id_ex_wb     = v.wb;
    id_ex_m      = v.m;
    id_ex_ex     = v.ex;
    id_ex_npc    = v.npc;
    read_data1   = v.rd1;
    read_data2   = v.rd2;
    sign_ext_imm = v.imm;
    rt           = v.rt;
    rd           = v.rd;
  endtask

  task automatic drive_mult(input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst);
    id_ex_valid  = 1'b1;
    id_ex_wb     = 2'b10;
    id_ex_m      = 3'b000;
    id_ex_ex     = 4'b1100;
    id_ex_npc    = 32'h0;
    read_data1   = a;
    read_data2   = b;
    sign_ext_imm = 32'h18;
    rt           = 5'd0;
    rd           = dst;
  endtask

  task automatic check_add_result(input string tag);
    check({tag, "_alu"}, ex_mem_alu_result, 32'd12);
    check({tag, "_rd"},  {27'd0, ex_mem_rd}, 32'd3);
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dst, input logic [31:0] exp);
    int cnt, bubble_bad;
    drive_mult(a, b, dst);
    #1;
    check("mul_issue_stall", {31'd0, stall}, 32'd1);
    cnt = 0;
    bubble_bad = 0;
    while (stall && cnt < 100) begin
      cnt++;
      tick();
      if (stall && (ex_mem_wb != 2'b00 || ex_mem_rd != 5'd0 || ex_mem_alu_result != 32'd0))
        bubble_bad++;
    end
    check("mul_stall_cycles", cnt, 32'd33);
    check("mul_bubbles", bubble_bad, 32'd0);
    tick();
    check("mul_result", ex_mem_alu_result, exp);
    check("mul_rd", {27'd0, ex_mem_rd}, {27'd0, dst});
    check("mul_wb", {30'd0, ex_mem_wb}, 32'd2);
    check("mul_zero", {31'd0, ex_mem_zero}, {31'd0, (exp == 32'd0)});
    drive(add_v);
    #1;
    check("mul_no_retrigger", {31'd0, stall}, 32'd0);
    tick();
    check_add_result("mul_followup_add");
  endtask

  initial begin
    //            valid wb     m       ex       npc           rd1           rd2           imm           rt     rd     e_alu         z     e_rd   e_wb   e_m     e_wdata       e_bt
    vecs[0]  = '{1'b1, 2'b10, 3'b000, 4'b1100, 32'h10,       32'd5,        32'd7,        32'h20,       5'd2,  5'd3,  32'd12,       1'b0, 5'd3,  2'b10, 3'b000, 32'd7,        32'h90};
    vecs[1]  = '{1'b1, 2'b00, 3'b100, 4'b0010, 32'h40,       32'h10,       32'h10,       32'd3,        5'd5,  5'd0,  32'd0,        1'b1, 5'd5,  2'b00, 3'b100, 32'h10,       32'h4C};
    vecs[2]  = '{1'b1, 2'b11, 3'b010, 4'b0001, 32'h100,      32'h100,      32'd0,        32'hFFFFFFFC, 5'd9,  5'd0,  32'hFC,       1'b0, 5'd9,  2'b11, 3'b010, 32'd0,        32'hF0};
    vecs[3]  = '{1'b1, 2'b00, 3'b001, 4'b0001, 32'h0,        32'h200,      32'hABCDEF12, 32'd8,        5'd4,  5'd0,  32'h208,      1'b0, 5'd4,  2'b00, 3'b001, 32'hABCDEF12, 32'h20};
    vecs[4]  = '{1'b1, 2'b10, 3'b000, 4'b1100, 32'h0,        32'hFFFFFFFF, 32'd1,        32'h2A,       5'd0,  5'd7,  32'd1,        1'b0, 5'd7,  2'b10, 3'b000, 32'd1,        32'hA8};
    vecs[5]  = '{1'b1, 2'b10, 3'b000, 4'b0110, 32'h8,        32'd1,        32'hFFFFFFFF, 32'h0,        5'd6,  5'd0,  32'd0,        1'b1, 5'd6,  2'b10, 3'b000, 32'hFFFFFFFF, 32'h8};
    vecs[6]  = '{1'b1, 2'b10, 3'b000, 4'b1100, 32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 32'h24,       5'd0,  5'd8,  32'hF000F000, 1'b0, 5'd8,  2'b10, 3'b000, 32'hFF00FF00, 32'h90};
    vecs[7]  = '{1'b1, 2'b10, 3'b000, 4'b1100, 32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 32'h25,       5'd0,  5'd8,  32'hFFF0FFF0, 1'b0, 5'd8,  2'b10, 3'b000, 32'hFF00FF00, 32'h94};
    vecs[8]  = '{1'b1, 2'b10, 3'b000, 4'b1100, 32'h0,        32'd3,        32'd5,        32'h22,       5'd0,  5'd1,  32'hFFFFFFFE, 1'b0, 5'd1,  2'b10, 3'b000, 32'd5,        32'h88};
    vecs[9]  = '{1'b1, 2'b10, 3'b000, 4'b1100, 32'h0,        32'd3,        32'd5,        32'h27,       5'd0,  5'd2,  32'd8,        1'b0, 5'd2,  2'b10, 3'b000, 32'd5,        32'h9C};
    vecs[10] = '{1'b0, 2'b11, 3'b111, 4'b1101, 32'h44,       32'd5,        32'd9,        32'h20,       5'd1,  5'd2,  32'd0,        1'b0, 5'd0,  2'b00, 3'b000, 32'd0,        32'd0};
    vecs[11] = '{1'b1, 2'b01, 3'b000, 4'b0001, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h55,       32'd1,        5'd12, 5'd0,  32'd0,        1'b1, 5'd12, 2'b01, 3'b000, 32'h55,       32'd0};
    add_v = vecs[0];

    rst = 1'b1;
    flush = 1'b0;
    drive(add_v);
    tick();
    tick();
    check("reset_alu",   ex_mem_alu_result, 32'd0);
    check("reset_wb",    {30'd0, ex_mem_wb}, 32'd0);
    check("reset_bt",    ex_mem_branch_target, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      tick();
      check($sformatf("v%0d_alu", i),   ex_mem_alu_result, vecs[i].e_alu);
      check($sformatf("v%0d_zero", i),  {31'd0, ex_mem_zero}, {31'd0, vecs[i].e_zero});
      check($sformatf("v%0d_rd", i),    {27'd0, ex_mem_rd}, {27'd0, vecs[i].e_rd});
      check($sformatf("v%0d_wb", i),    {30'd0, ex_mem_wb}, {30'd0, vecs[i].e_wb});
      check($sformatf("v%0d_m", i),     {29'd0, ex_mem_branch, ex_mem_memread, ex_mem_memwrite},
                                        {29'd0, vecs[i].e_m});
      check($sformatf("v%0d_wdata", i), ex_mem_write_data, vecs[i].e_wdata);
      check($sformatf("v%0d_bt", i),    ex_mem_branch_target, vecs[i].e_bt);
      check($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
    end

    run_mult(32'h0000FFFF, 32'h00010001, 5'd10, 32'hFFFFFFFF);
    run_mult(32'h12345678, 32'h00000010, 5'd11, 32'h23456780);

    // Flush ten cycles into a multiply.
    drive_mult(32'h0000FFFF, 32'h00010001, 5'd10);
    for (int i = 0; i < 10; i++) tick();
    check("flush_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_ex_valid = 1'b0;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_alu", ex_mem_alu_result, 32'd0);
    check("flush_wb", {30'd0, ex_mem_wb}, 32'd0);
    drive(add_v);
    tick();
    check_add_result("flush_followup_add");

    // Flush landing in DONE discards the product.
    drive_mult(32'h0000FFFF, 32'h00010001, 5'd10);
    #1;
    for (int i = 0; i < 100 && stall; i++) tick();
    check("done_flush_reach", {31'd0, stall}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("done_flush_alu", ex_mem_alu_result, 32'd0);
    check("done_flush_wb", {30'd0, ex_mem_wb}, 32'd0);
    check("done_flush_rd", {27'd0, ex_mem_rd}, 32'd0);
    drive(add_v);
    tick();
    check_add_result("done_flush_followup_add");

    // Asynchronous reset between edges mid-multiply.
    drive_mult(32'h12345678, 32'h00000010, 5'd11);
    for (int i = 0; i < 5; i++) tick();
    check("rst_pre_stall", {31'd0, stall}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_stall", {31'd0, stall}, 32'd0);
    check("rst_async_alu", ex_mem_alu_result, 32'd0);
    check("rst_async_wb", {30'd0, ex_mem_wb}, 32'd0);
    rst = 1'b0;
    drive(add_v);
    tick();
    check_add_result("rst_followup_add");
    check("rst_followup_stall", {31'd0, stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
